queue_ctrl: RTL and testbench
=============================

QUEUE_CTRL -- requirements
Module: queue_ctrl

Interface
REQ-001 Parameter MAX_P, default 7, is the queue capacity in persons; legal range 1..7.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 back_sensor  input  1  level from the entry photo sensor; a rising edge means one person joined the queue.
REQ-005 front_sensor  input  1  level from the exit photo sensor; a rising edge means one person left the queue.
REQ-006 Tcount  input  2  number of open tellers (0..3); 0 means the service is closed.
REQ-007 Pcount  output  3  current number of persons in the queue.
REQ-008 Wtime  output  5  estimated waiting time read from the wait-time table.
REQ-009 full  output  1  high while Pcount == MAX_P.
REQ-010 empty  output  1  high while Pcount == 0.
REQ-011 alarm  output  1  sticky error flag: entry while full or exit while empty.

Function
REQ-012 Each sensor shall have a one-flop history register; an event is sensor==1 and history==0 in the same cycle.
REQ-013 An event sampled at edge n shall update Pcount at edge n, so the new value is visible in cycle n+1.
REQ-014 Entry event only, with Pcount < MAX_P: Pcount increments by 1.
REQ-015 Exit event only, with Pcount > 0: Pcount decrements by 1.
REQ-016 Entry and exit events in the same cycle: Pcount is unchanged, whatever its value, and alarm is not set.
REQ-017 Entry event only, while full: Pcount holds at MAX_P and alarm sets; no wrap to 0.
REQ-018 Exit event only, while empty: Pcount holds at 0 and alarm sets; no wrap to 7.
REQ-019 Once alarm is high it shall stay high until rst.
REQ-020 A sensor held high shall produce only one event; the next event requires the sensor to return low for at least one cycle.
REQ-021 The table index shall be {Tcount, Pcount} (5 bits, Tcount in the MSBs).
REQ-022 Wtime shall be a register loaded every cycle from the table output for the current index, so it lags a Pcount or Tcount change by exactly one cycle.
REQ-023 Table contents for Tcount=1, Pcount 1..7: 3,6,9,12,15,18,21.
REQ-024 Table contents for Tcount=2, Pcount 1..7: 3,4,6,7,9,10,12.
REQ-025 Table contents for Tcount=3, Pcount 1..7: 3,4,5,6,7,8,9.
REQ-026 For every other index (Tcount=0 or Pcount=0) the table output shall be 0.
REQ-027 full and empty shall be decoded combinationally from the registered Pcount, so they are glitch-free and have no extra latency.
REQ-028 A Tcount change alone shall not alter Pcount; only Wtime updates, one cycle later.

Reset
REQ-029 While rst is high at a clock edge, the block shall set Pcount=0, Wtime=0, alarm=0, and both sensor history registers to 0.
REQ-030 After reset, empty=1 and full=0.
REQ-031 An event coinciding with an rst edge shall be discarded.
REQ-032 If a sensor is still high when rst deasserts, no event shall fire until that sensor goes low and then high again.

Structure
REQ-033 A shared package shall hold MAX_P, the widths (PW=3, TW=2, WW=5), and the wait-time table constants.
REQ-034 The wait-time lookup shall be one combinational sub-module, wait_rom (index in, Wtime out), instantiated once.
REQ-035 The counter, edge detectors, flags and output register shall stay in queue_ctrl.

Verification
REQ-036 Scenario 1: rst, then Tcount=1 and three back_sensor pulses -> Pcount=3 and, one cycle later, Wtime=9; empty=0.
REQ-037 Scenario 2: Tcount=2, ten entry pulses -> Pcount saturates at 7 with full=1 and Wtime=12; alarm=1 after the 8th pulse.
REQ-038 Scenario 3: Pcount=0, one front_sensor pulse -> Pcount stays 0, empty=1, alarm=1.
REQ-039 Scenario 4: Pcount=4, both sensors rise in the same cycle -> Pcount stays 4, alarm=0; back_sensor held high for 5 cycles -> Pcount=5 only.
REQ-040 Scenario 5: Pcount=5, Tcount steps 3->0 -> Wtime goes 7 to 0 one cycle after the change; Pcount stays 5.
REQ-041 Scenario 6: rst asserted at Pcount=6 with a sensor held high -> all outputs 0 / empty=1, and no event fires until that sensor toggles low then high.

Source files
------------

// File: rtl/queue_ctrl_pkg.sv
// Shared constants for the queue controller: widths, default capacity and the
// wait-time table indexed by {tellers, persons}.
package queue_ctrl_pkg;

  localparam int PW    = 3;
  localparam int TW    = 2;
  localparam int WW    = 5;
  localparam int IW    = TW + PW;
  localparam int MAX_P = 7;

  // Row = open tellers, column = persons waiting; row 0 and column 0 read as 0.
  localparam logic [WW-1:0] WAIT_TBL [0:(1<<TW)-1][0:(1<<PW)-1] = '{
    '{5'd0, 5'd0, 5'd0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0},
    '{5'd0, 5'd3, 5'd6, 5'd9,  5'd12, 5'd15, 5'd18, 5'd21},
    '{5'd0, 5'd3, 5'd4, 5'd6,  5'd7,  5'd9,  5'd10, 5'd12},
    '{5'd0, 5'd3, 5'd4, 5'd5,  5'd6,  5'd7,  5'd8,  5'd9}
  };

  function automatic logic [WW-1:0] wait_lookup(input logic [IW-1:0] idx);
    return WAIT_TBL[idx[IW-1:PW]][idx[PW-1:0]];
  endfunction

endpackage

// File: rtl/wait_rom.sv
// Combinational wait-time lookup; index is {Tcount, Pcount}.
module wait_rom
  import queue_ctrl_pkg::*;
(
  input  logic [IW-1:0] idx,
  output logic [WW-1:0] wtime
);

  always_comb begin
    wtime = wait_lookup(idx);
  end

endmodule

// File: rtl/queue_ctrl.sv
// Queue occupancy counter driven by entry/exit photo sensors, with full/empty
// flags, a sticky misuse alarm and a registered wait-time estimate.
module queue_ctrl
  import queue_ctrl_pkg::*;
#(
  parameter int MAX_P = queue_ctrl_pkg::MAX_P
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          back_sensor,
  input  logic          front_sensor,
  input  logic [TW-1:0] Tcount,
  output logic [PW-1:0] Pcount,
  output logic [WW-1:0] Wtime,
  output logic          full,
  output logic          empty,
  output logic          alarm
);

  localparam logic [PW-1:0] MAX_CNT = PW'(MAX_P);

  logic          back_hist;
  logic          front_hist;
  logic          back_armed;
  logic          front_armed;
  logic          entry_ev;
  logic          exit_ev;
  logic [PW-1:0] pcount_q;
  logic [PW-1:0] cnt_nxt;
  logic          alarm_q;
  logic          alarm_set;
  logic [WW-1:0] wtime_q;
  logic [WW-1:0] rom_wtime;
  logic [IW-1:0] rom_idx;

  // The arm flags stop a sensor that is already high at reset release from
  // looking like a fresh rising edge; it must be seen low first.
  always_ff @(posedge clk) begin
    if (rst) begin
      back_hist   <= 1'b0;
      front_hist  <= 1'b0;
      back_armed  <= ~back_sensor;
      front_armed <= ~front_sensor;
    end else begin
      back_hist   <= back_sensor;
      front_hist  <= front_sensor;
      back_armed  <= back_armed | ~back_sensor;
      front_armed <= front_armed | ~front_sensor;
    end
  end

  always_comb begin
    entry_ev = back_sensor & ~back_hist & back_armed;
    exit_ev  = front_sensor & ~front_hist & front_armed;
  end

  // Simultaneous entry and exit cancel out; misuse holds the count and alarms.
  always_comb begin
    cnt_nxt   = pcount_q;
    alarm_set = 1'b0;
    case ({entry_ev, exit_ev})
      2'b10: begin
        if (pcount_q == MAX_CNT) alarm_set = 1'b1;
        else                     cnt_nxt   = pcount_q + 1'b1;
      end
      2'b01: begin
        if (pcount_q == '0) alarm_set = 1'b1;
        else                cnt_nxt   = pcount_q - 1'b1;
      end
      default: begin
        cnt_nxt   = pcount_q;
        alarm_set = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcount_q <= '0;
      alarm_q  <= 1'b0;
      wtime_q  <= '0;
    end else begin
      pcount_q <= cnt_nxt;
      alarm_q  <= alarm_q | alarm_set;
      wtime_q  <= rom_wtime;
    end
  end

  assign rom_idx = {Tcount, pcount_q};

  wait_rom u_wait_rom (
    .idx   (rom_idx),
    .wtime (rom_wtime)
  );

  assign Pcount = pcount_q;
  assign Wtime  = wtime_q;
  assign alarm  = alarm_q;
  assign full   = (pcount_q == MAX_CNT);
  assign empty  = (pcount_q == '0);

endmodule

// File: tb/tb_queue_ctrl.sv
// Directed scenarios plus a random phase for queue_ctrl, checked against a
// cycle-level occupancy model built from the sensor levels the bench drives.
module tb_queue_ctrl;

  localparam int MAX_P = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       back_sensor = 1'b0;
  logic       front_sensor = 1'b0;
  logic [1:0] tcount = 2'd0;
  logic [2:0] pcount;
  logic [4:0] wtime;
  logic       full;
  logic       empty;
  logic       alarm;

  always #5 clk = ~clk;

  queue_ctrl #(.MAX_P(MAX_P)) dut (
    .clk          (clk),
    .rst          (rst),
    .back_sensor  (back_sensor),
    .front_sensor (front_sensor),
    .Tcount       (tcount),
    .Pcount       (pcount),
    .Wtime        (wtime),
    .full         (full),
    .empty        (empty),
    .alarm        (alarm)
  );

  int tests_run = 0;
  int tests_failed = 0;

  int   m_cnt = 0;
  int   m_wt = 0;
  logic m_alarm = 1'b0;
  logic prev_b = 1'b0;
  logic prev_f = 1'b0;
  int   t2_tbl [8] = '{0, 3, 4, 6, 7, 9, 10, 12};

  function automatic int ref_wait(input int t, input int p);
    if (t == 0 || p == 0) return 0;
    if (t == 1) return 3 * p;
    if (t == 2) return t2_tbl[p];
    return p + 2;
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_all();
    check("pcount", int'(pcount), m_cnt);
    check("wtime", int'(wtime), m_wt);
    check("full", int'(full), int'(m_cnt == MAX_P));
    check("empty", int'(empty), int'(m_cnt == 0));
    check("alarm", int'(alarm), int'(m_alarm));
  endtask

  // One clock: drive at negedge, update the model at posedge, sample 1ns later.
  task automatic step(input logic b, input logic f, input logic [1:0] t, input logic r);
    logic ev_in, ev_out;
    @(negedge clk);
    back_sensor  = b;
    front_sensor = f;
    tcount       = t;
    rst          = r;
    @(posedge clk);
    if (r) begin
      m_cnt   = 0;
      m_wt    = 0;
      m_alarm = 1'b0;
    end else begin
      m_wt   = ref_wait(int'(t), m_cnt);
      ev_in  = b && !prev_b;
      ev_out = f && !prev_f;
      if (ev_in && !ev_out) begin
        if (m_cnt == MAX_P) m_alarm = 1'b1;
        else                m_cnt++;
      end else if (ev_out && !ev_in) begin
        if (m_cnt == 0) m_alarm = 1'b1;
        else            m_cnt--;
      end
    end
    prev_b = b;
    prev_f = f;
    #1;
    check_all();
  endtask

  task automatic do_reset(input logic b, input logic f, input logic [1:0] t);
    step(b, f, t, 1'b1);
    step(b, f, t, 1'b1);
  endtask

  task automatic entry_pulses(input int n, input logic [1:0] t);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, t, 1'b0);
      step(1'b0, 1'b0, t, 1'b0);
    end
  endtask

  initial begin
    // Reset state
    do_reset(1'b0, 1'b0, 2'd0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);

    // Scenario 1: three entries with one teller
    do_reset(1'b0, 1'b0, 2'd1);
    entry_pulses(3, 2'd1);
    check("s1_pcount", int'(pcount), 3);
    check("s1_wtime", int'(wtime), 9);
    check("s1_empty", int'(empty), 0);

    // Scenario 2: saturation with two tellers
    do_reset(1'b0, 1'b0, 2'd2);
    entry_pulses(7, 2'd2);
    check("s2_alarm_before", int'(alarm), 0);
    entry_pulses(1, 2'd2);
    check("s2_alarm_8th", int'(alarm), 1);
    entry_pulses(2, 2'd2);
    check("s2_pcount", int'(pcount), 7);
    check("s2_full", int'(full), 1);
    check("s2_wtime", int'(wtime), 12);

    // Scenario 3: exit while empty
    do_reset(1'b0, 1'b0, 2'd1);
    step(1'b0, 1'b1, 2'd1, 1'b0);
    step(1'b0, 1'b0, 2'd1, 1'b0);
    check("s3_pcount", int'(pcount), 0);
    check("s3_empty", int'(empty), 1);
    check("s3_alarm", int'(alarm), 1);

    // Scenario 4: simultaneous events, then a held sensor
    do_reset(1'b0, 1'b0, 2'd3);
    entry_pulses(4, 2'd3);
    step(1'b1, 1'b1, 2'd3, 1'b0);
    step(1'b0, 1'b0, 2'd3, 1'b0);
    check("s4_pcount_both", int'(pcount), 4);
    check("s4_alarm_both", int'(alarm), 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'd3, 1'b0);
    step(1'b0, 1'b0, 2'd3, 1'b0);
    check("s4_pcount_held", int'(pcount), 5);

    // Scenario 5: teller count stepping down at five persons
    step(1'b0, 1'b0, 2'd3, 1'b0);
    check("s5_wtime_t3", int'(wtime), 7);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    check("s5_wtime_t0", int'(wtime), 0);
    check("s5_pcount", int'(pcount), 5);

    // Scenario 6: reset with a sensor held high
    entry_pulses(1, 2'd1);
    step(1'b1, 1'b0, 2'd1, 1'b0);
    do_reset(1'b1, 1'b0, 2'd1);
    check("s6_pcount_rst", int'(pcount), 0);
    check("s6_wtime_rst", int'(wtime), 0);
    check("s6_empty_rst", int'(empty), 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd1, 1'b0);
    check("s6_no_event", int'(pcount), 0);
    step(1'b0, 1'b0, 2'd1, 1'b0);
    step(1'b1, 1'b0, 2'd1, 1'b0);
    check("s6_after_toggle", int'(pcount), 1);

    // Random phase
    do_reset(1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 2) == 0),
           2'($urandom_range(0, 3)), logic'($urandom_range(0, 60) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule
